// File: rtl/slice_adder_seq.sv
// Multi-cycle wide adder: a SLICE-bit ripple slice is reused over WIDTH/SLICE cycles,
// with valid/ready handshakes on both the operand and the result side.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one slice added per cycle, low slice first
// DONE  | result held on s/c_out/ovf until out_ready
module slice_adder_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cy;
  logic             last;
  logic             msb_cin;

  always_comb begin
    {slice_cy, slice_sum} = {1'b0, xr[SLICE-1:0]} + {1'b0, yr[SLICE-1:0]}
                          + {{SLICE{1'b0}}, carry};
  end

  assign last    = (cnt == CW'(N - 1));
  // Carry into the MSB, recovered from the top bit of the last slice.
  assign msb_cin = xr[SLICE-1] ^ yr[SLICE-1] ^ slice_sum[SLICE-1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xr    <= '0;
      yr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr    <= x;
            yr    <= y;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          xr    <= xr >> SLICE;
          yr    <= yr >> SLICE;
          // Insert each slice at the top so slice 0 lands in s[SLICE-1:0] after N shifts.
          s     <= (s >> SLICE) | (WIDTH'(slice_sum) << (WIDTH - SLICE));
          carry <= slice_cy;
          cnt   <= cnt + CW'(1);
          if (last) begin
            c_out <= slice_cy;
            ovf   <= msb_cin ^ slice_cy;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_slice_adder_seq.sv
// Bench for slice_adder_seq: directed literal cases, backpressure, streaming, mid-op reset,
// a single-slice instance, and random traffic checked against an arithmetic reference model.
module tb_slice_adder_seq;

  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf, busy;
  logic [W-1:0]  x, y, s;
  logic          in_valid2, in_ready2, c_in2, out_valid2, out_ready2, c_out2, ovf2, busy2;
  logic [7:0]    x2, y2, s2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slice_adder_seq #(.WIDTH(W), .SLICE(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  slice_adder_seq #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .x(x2), .y(y2), .c_in(c_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .s(s2), .c_out(c_out2), .ovf(ovf2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide addition; overflow when same-sign operands give a different-sign sum.
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci);
    logic [16:0] t;
    logic        ov;
    t  = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    ov = (a[15] == b[15]) && (t[15] != a[15]);
    return {ov, t};
  endfunction

  // Cycle-level expectation: 0 idle, 1 running (left cycles to go), 2 result waiting.
  int          m = 0;
  int          left = 0;
  bit          synced = 1'b0;
  bit          after_rst = 1'b0;
  logic [17:0] q[$];

  always @(negedge clk) begin
    if (synced) begin
      chk("mon_in_ready", 32'(in_ready), 32'(m == 0));
      chk("mon_out_valid", 32'(out_valid), 32'(m == 2));
      chk("mon_busy", 32'(busy), 32'(m != 0));
      if (m == 2) begin
        chk("mon_queue_depth", 32'(q.size()), 32'd1);
        if (q.size() > 0) chk("mon_result", 32'({ovf, c_out, s}), 32'(q[0]));
      end
      if (after_rst) chk("mon_reset_outputs", 32'({ovf, c_out, s}), 32'd0);
    end
    after_rst = 1'b0;
    if (!rst_n) begin
      synced    = 1'b1;
      m         = 0;
      after_rst = 1'b1;
      q.delete();
    end else if (m == 0) begin
      if (in_valid) begin
        q.push_back(ref_add(x, y, c_in));
        m    = 1;
        left = N;
      end
    end else if (m == 1) begin
      left--;
      if (left == 0) m = 2;
    end else if (out_ready) begin
      void'(q.pop_front());
      m = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_idle_bound", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_result_bound", 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input bit scramble);
    int n = 0;
    wait_idle();
    out_ready = 1'b1;
    x = a; y = b; c_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && n < 30) begin
      if (scramble) begin
        x = 16'($urandom); y = 16'($urandom); c_in = 1'($urandom);
      end
      @(posedge clk); #1; n++;
    end
    chk("op_latency", 32'(n), 32'(N));
    chk("op_s", 32'(s), 32'(es));
    chk("op_c_out", 32'(c_out), 32'(ec));
    chk("op_ovf", 32'(ovf), 32'(eo));
    @(posedge clk); #1;
    chk("op_released", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int          n;
    int          idx;
    int          cyc;
    int          seen;
    int          at[3];
    bit          prev_ready;
    logic [15:0] pa[3];
    logic [15:0] pb[3];
    logic [8:0]  t8;
    logic        ov8;

    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; c_in = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; x2 = '0; y2 = '0; c_in2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'({ovf, c_out, s}), 32'd0);
    chk("rst8_state", 32'({in_ready2, out_valid2, busy2}), 32'b100);
    rst_n = 1'b1;

    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b1);

    // Backpressure with a second request already pending.
    wait_idle();
    out_ready = 1'b0;
    x = 16'hABCD; y = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    x = 16'h0F0F; y = 16'h00F1; c_in = 1'b1;
    wait_result(n);
    chk("bp_latency", 32'(n), 32'(N));
    for (int i = 0; i < 10; i++) begin
      chk("bp_held_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_held_result", 32'({ovf, c_out, s}), 32'({1'b0, 1'b0, 16'hBCDE}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_hs_idle", 32'({in_ready, out_valid, busy}), 32'b100);
    @(posedge clk); #1;
    chk("bp_pending_captured", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_result(n);
    chk("bp_second_result", 32'({ovf, c_out, s}), 32'({1'b0, 1'b0, 16'h1001}));
    @(posedge clk); #1;

    // Streaming: accepts must land N+2 cycles apart.
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      pa[i] = 16'($urandom); pb[i] = 16'($urandom);
    end
    out_ready = 1'b1;
    x = pa[0]; y = pb[0]; c_in = 1'($urandom); in_valid = 1'b1;
    idx = 0; cyc = 0; prev_ready = in_ready;
    while (idx < 3 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (prev_ready && busy) begin
        at[idx] = cyc;
        idx++;
        if (idx < 3) begin
          x = pa[idx]; y = pb[idx]; c_in = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      prev_ready = in_ready;
    end
    chk("stream_accepts", 32'(idx), 32'd3);
    chk("stream_gap01", 32'(at[1] - at[0]), 32'(N + 2));
    chk("stream_gap12", 32'(at[2] - at[1]), 32'(N + 2));
    wait_idle();

    // Reset while the counter is at slice 2.
    x = 16'h5A5A; y = 16'h1234; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_state", 32'({in_ready, out_valid, busy}), 32'b100);
    chk("midrst_s", 32'(s), 32'd0);
    seen = 0;
    repeat (N + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);

    // Single-slice instance.
    x2 = 8'hF0; y2 = 8'h20; c_in2 = 1'b0; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 10) begin @(posedge clk); #1; n++; end
    chk("w8_latency", 32'(n), 32'd1);
    chk("w8_result", 32'({ovf2, c_out2, s2}), 32'({1'b0, 1'b1, 8'h10}));
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      x2 = 8'($urandom); y2 = 8'($urandom); c_in2 = 1'($urandom); in_valid2 = 1'b1;
      t8  = {1'b0, x2} + {1'b0, y2} + {8'd0, c_in2};
      ov8 = (x2[7] == y2[7]) && (t8[7] != x2[7]);
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      n = 0;
      while (!out_valid2 && n < 10) begin @(posedge clk); #1; n++; end
      chk("w8_rand_latency", 32'(n), 32'd1);
      chk("w8_rand_result", 32'({ovf2, c_out2, s2}), 32'({ov8, t8}));
      @(posedge clk); #1;
    end

    // Random traffic with occasional resets; the monitor checks every cycle.
    repeat (500) begin
      in_valid  = 1'($urandom);
      x         = 16'($urandom);
      y         = 16'($urandom);
      c_in      = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 4) begin @(posedge clk); #1; end
    chk("final_idle", 32'({in_ready, busy}), 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
